// File: rtl/rca_multicycle.sv
// Multi-cycle ripple-carry adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with the inter-slice carry kept in a register. Valid/ready on both sides.
`timescale 1ns/1ps
module rca_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("rca_multicycle: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             co_q, co_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   sum;
  logic             c_msb;
  int               base;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

  always_comb begin
    base    = CHUNK * int'(cnt_q);
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of this slice, recovered from its sum bit.
    c_msb   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];

    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : ci;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        s_d[base +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          co_d    = sum[CHUNK];
          ovf_d   = c_msb ^ sum[CHUNK];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_rca_multicycle.sv
// Directed bench for rca_multicycle: a 32/4 instance and a degenerate 4/4 instance,
// expected results queued at accept and compared when out_valid is seen.
`timescale 1ns/1ps
module tb_rca_multicycle;
  typedef struct packed {logic [31:0] s; logic co; logic ovf;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid32 = 0, in_ready32, ci32 = 0, sub32 = 0;
  logic        out_valid32, out_ready32 = 0, co32, ovf32;
  logic [31:0] a32 = 0, b32 = 0, s32;

  logic        in_valid4 = 0, in_ready4, ci4 = 0, sub4 = 0;
  logic        out_valid4, out_ready4 = 0, co4, ovf4;
  logic [3:0]  a4 = 0, b4 = 0, s4;

  rca_multicycle #(.WIDTH(32), .CHUNK(4)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .ci(ci32), .sub(sub32), .out_valid(out_valid32),
    .out_ready(out_ready32), .s(s32), .co(co32), .ovf(ovf32));

  rca_multicycle #(.WIDTH(4), .CHUNK(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .ci(ci4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .s(s4), .co(co4), .ovf(ovf4));

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic co, input logic ovf);
    exp_t e;
    e.s = s; e.co = co; e.ovf = ovf;
    return e;
  endfunction

  // Independent reference: full-width sum, overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    logic [32:0] full;
    logic [31:0] mask, bb, aa;
    exp_t e;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa    = a & mask;
    bb    = (sub ? ~b : b) & mask;
    full  = {1'b0, aa} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : ci)};
    e.s   = full[31:0] & mask;
    e.co  = full[w];
    e.ovf = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    return e;
  endfunction

  task automatic pop_cmp(input string tag, input logic [31:0] s, input logic co, input logic ovf);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty got s=0x%0h want an entry", tag, s);
    end else begin
      e = sb.pop_front();
      chk({tag, " s"}, s, e.s);
      chk({tag, " co"}, {31'd0, co}, {31'd0, e.co});
      chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
    end
  endtask

  task automatic accept32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input logic sub, input string tag);
    int n = 0;
    while (!in_ready32 && n < 50) begin tick; n++; end
    chk({tag, " in_ready"}, {31'd0, in_ready32}, 32'd1);
    a32 = a; b32 = b; ci32 = ci; sub32 = sub; in_valid32 = 1;
    tick;
    in_valid32 = 0;
    // Scramble operands: only the accept-edge values may matter.
    a32 = ~a; b32 = ~b; ci32 = ~ci; sub32 = ~sub;
  endtask

  task automatic wait_out32(input string tag);
    int n = 0;
    while (!out_valid32 && n < 100) begin tick; n++; end
    chk({tag, " latency"}, n, 32'd8);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic sub, input exp_t e, input string tag);
    accept32(a, b, ci, sub, tag);
    sb.push_back(e);
    wait_out32(tag);
    pop_cmp(tag, s32, co32, ovf32);
    out_ready32 = 1;
    tick;
    out_ready32 = 0;
    chk({tag, " out_valid drop"}, {31'd0, out_valid32}, 32'd0);
    chk({tag, " in_ready back"}, {31'd0, in_ready32}, 32'd1);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sub);
    int n = 0;
    a4 = a; b4 = b; ci4 = ci; sub4 = sub; in_valid4 = 1;
    tick;
    in_valid4 = 0;
    sb.push_back(model(4, {28'd0, a}, {28'd0, b}, ci, sub));
    while (!out_valid4 && n < 20) begin tick; n++; end
    chk("w4 latency", n, 32'd1);
    pop_cmp("w4", {28'd0, s4}, co4, ovf4);
    out_ready4 = 1;
    tick;
    out_ready4 = 0;
  endtask

  initial begin
    int hits;
    logic [31:0] ra, rb;
    logic rci, rsub;

    // Reset state
    tick; tick;
    chk("rst in_ready", {31'd0, in_ready32}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid32}, 32'd0);
    chk("rst s", s32, 32'd0);
    chk("rst co/ovf", {30'd0, co32, ovf32}, 32'd0);
    rst_n = 1;
    tick;

    op32(32'd5, 32'd3, 0, 0, mk(32'h8, 0, 0), "add5_3");
    op32(32'hFFFF_FFFF, 32'd1, 0, 0, mk(32'h0, 1, 0), "ripple_b1");
    op32(32'hFFFF_FFFF, 32'd0, 1, 0, mk(32'h0, 1, 0), "ripple_ci");
    op32(32'h8000_0000, 32'd1, 0, 1, mk(32'h7FFF_FFFF, 1, 1), "sub_ovf");
    op32(32'd3, 32'd5, 1, 1, mk(32'hFFFF_FFFE, 0, 0), "sub_neg");
    op32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1, mk(32'h8000_0000, 0, 1), "sub_ovf2");

    // Backpressure: result held, new operands ignored while DONE
    accept32(32'h7FFF_FFFF, 32'd1, 0, 0, "bp");
    sb.push_back(mk(32'h8000_0000, 0, 1));
    wait_out32("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid32 = 1; a32 = $urandom; b32 = $urandom; ci32 = 1; sub32 = 1;
      tick;
      chk("bp s stable", s32, 32'h8000_0000);
      chk("bp co/ovf stable", {30'd0, co32, ovf32}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready32}, 32'd0);
      chk("bp out_valid", {31'd0, out_valid32}, 32'd1);
    end
    pop_cmp("bp", s32, co32, ovf32);
    in_valid32 = 0; out_ready32 = 1;
    tick;
    out_ready32 = 0;
    chk("bp release in_ready", {31'd0, in_ready32}, 32'd1);
    chk("bp release out_valid", {31'd0, out_valid32}, 32'd0);
    tick;
    chk("bp no phantom accept", {31'd0, in_ready32}, 32'd1);

    // Reset during chunk 3 aborts the operation
    accept32(32'h1234_5678, 32'h1111_1111, 0, 0, "rst_mid");
    tick; tick; tick;
    rst_n = 0;
    #1;
    chk("rst_mid out_valid", {31'd0, out_valid32}, 32'd0);
    chk("rst_mid s", s32, 32'd0);
    chk("rst_mid co", {31'd0, co32}, 32'd0);
    chk("rst_mid in_ready", {31'd0, in_ready32}, 32'd1);
    tick; tick;
    rst_n = 1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid32) hits++;
    end
    chk("rst_mid no out_valid", hits, 32'd0);
    op32(32'h1234_5678, 32'h1111_1111, 0, 0, mk(32'h2345_6789, 0, 0), "after_rst");

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
      op32(ra, rb, rci, rsub, model(32, ra, rb, rci, rsub), "rand32");
    end

    // Exhaustive single-chunk instance
    for (int sb_i = 0; sb_i < 2; sb_i++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            op4(4'(x), 4'(y), 1'(c), 1'(sb_i));

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
